// File: rtl/jk_bank_driver_pkg.sv
// jk_bank_driver_pkg: shared FSM states, JK excitation encodings and counter sizing.
package jk_bank_driver_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_e;
  localparam logic [1:0] JK_HOLD  = 2'b00;
  localparam logic [1:0] JK_SET   = 2'b10;
  localparam logic [1:0] JK_RESET = 2'b01;
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/jk_bank_driver_excitation.sv
// jk_excitation: per-bit JK excitation for a Q->T transition, don't-cares resolved to 0.
module jk_excitation
  import jk_bank_driver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {j[i], k[i]} = (~q[i] & t[i]) ? JK_SET : (q[i] & ~t[i]) ? JK_RESET : JK_HOLD;
  end
endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a JK flip-flop bank to a target state, verifies Q and retries on mismatch.
module jk_bank_driver
  import jk_bank_driver_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int MAX_RETRY     = 2
) (
  input  logic                          i_CLOCK_POS,
  input  logic                          i_RESET_NEG,
  input  logic [WIDTH-1:0]              i_TARGET,
  input  logic                          i_TARGET_VALID,
  output logic                          o_TARGET_READY,
  input  logic [WIDTH-1:0]              i_Q_FEEDBACK,
  output logic [WIDTH-1:0]              o_SIGNAL_J,
  output logic [WIDTH-1:0]              o_SIGNAL_K,
  output logic                          o_DONE,
  output logic                          o_ERROR,
  output logic [cnt_w(MAX_RETRY)-1:0]   o_RETRY_COUNT
);
  localparam int RW = cnt_w(MAX_RETRY);
  localparam int SW = cnt_w(SETTLE_CYCLES);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  state_e state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d, j_q, j_d, k_q, k_d, exc_j, exc_k;
  logic done_q, done_d, error_q, error_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [SW-1:0] settle_q, settle_d;
  jk_excitation #(.WIDTH(WIDTH)) u_exc (
    .q(i_Q_FEEDBACK),
    .t((state_q == IDLE) ? i_TARGET : target_q),
    .j(exc_j),
    .k(exc_k)
  );
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    j_d      = '0;
    k_d      = '0;
    done_d   = 1'b0;
    error_d  = 1'b0;
    retry_d  = retry_q;
    settle_d = settle_q;
    case (state_q)
      IDLE: if (i_TARGET_VALID) begin
        state_d  = DRIVE;
        target_d = i_TARGET;
        retry_d  = '0;
        j_d      = exc_j;
        k_d      = exc_k;
      end
      DRIVE: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
      SETTLE: begin
        state_d  = (settle_q == SETTLE_LAST) ? CHECK : SETTLE;
        settle_d = settle_q + 1'b1;
      end
      CHECK: if (i_Q_FEEDBACK == target_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (retry_q != RETRY_LAST) begin
        state_d = DRIVE;
        retry_d = retry_q + 1'b1;
        j_d     = exc_j;
        k_d     = exc_k;
      end else begin
        state_d = IDLE;
        error_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_CLOCK_POS or negedge i_RESET_NEG)
    if (!i_RESET_NEG) begin
      state_q  <= IDLE;
      target_q <= '0;
      j_q      <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      retry_q  <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      j_q      <= j_d;
      k_q      <= k_d;
      done_q   <= done_d;
      error_q  <= error_d;
      retry_q  <= retry_d;
      settle_q <= settle_d;
    end
  assign o_TARGET_READY = state_q == IDLE;
  assign o_SIGNAL_J     = j_q;
  assign o_SIGNAL_K     = k_q;
  assign o_DONE         = done_q;
  assign o_ERROR        = error_q;
  assign o_RETRY_COUNT  = retry_q;
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed vectors and corner sequences against a behavioural JK bank.
module tb_jk_bank_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] target = '0;
  logic valid = 1'b0;
  logic ready, done, error;
  logic [3:0] sig_j, sig_k, bank_q, load_val;
  logic [1:0] retry;
  logic load_en = 1'b0, stuck0 = 1'b0, skip_req = 1'b0, skip_used = 1'b0;
  int tests = 0, fails = 0;
  typedef struct {
    logic [3:0] q0;
    logic [3:0] tgt;
    logic [3:0] exp_j;
    logic [3:0] exp_k;
  } vec_t;
  vec_t vecs[6];
  always #5 clk = ~clk;
  jk_bank_driver #(.WIDTH(4), .SETTLE_CYCLES(1), .MAX_RETRY(2)) dut (
    .i_CLOCK_POS(clk),
    .i_RESET_NEG(rst_n),
    .i_TARGET(target),
    .i_TARGET_VALID(valid),
    .o_TARGET_READY(ready),
    .i_Q_FEEDBACK(bank_q),
    .o_SIGNAL_J(sig_j),
    .o_SIGNAL_K(sig_k),
    .o_DONE(done),
    .o_ERROR(error),
    .o_RETRY_COUNT(retry)
  );
  always @(posedge clk)
    if (load_en) begin
      bank_q    <= load_val;
      skip_used <= 1'b0;
    end else if (skip_req && !skip_used && |(sig_j | sig_k))
      skip_used <= 1'b1;
    else
      bank_q <= ((sig_j & ~bank_q) | (~sig_k & bank_q)) & ~{3'b000, stuck0};
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic load(input logic [3:0] v);
    load_val = v;
    load_en  = 1'b1;
    step();
    load_en = 1'b0;
  endtask
  task automatic accept(input logic [3:0] t);
    target = t;
    valid  = 1'b1;
    step();
    valid = 1'b0;
  endtask
  initial begin
    vecs[0] = '{4'b0000, 4'b1010, 4'b1010, 4'b0000};
    vecs[1] = '{4'b1100, 4'b0110, 4'b0010, 4'b1000};
    vecs[2] = '{4'b0110, 4'b0110, 4'b0000, 4'b0000};
    vecs[3] = '{4'b1111, 4'b0000, 4'b0000, 4'b1111};
    vecs[4] = '{4'b0101, 4'b1010, 4'b1010, 4'b0101};
    vecs[5] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000};
    repeat (2) @(negedge clk);
    chk("rst_j", 8'(sig_j), 8'h0);
    chk("rst_k", 8'(sig_k), 8'h0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 8'(ready), 8'h1);
    chk("rst_done", 8'(done), 8'h0);
    chk("rst_error", 8'(error), 8'h0);
    chk("rst_retry", 8'(retry), 8'h0);
    @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      load(vecs[v].q0);
      chk($sformatf("v%0d_ready", v), 8'(ready), 8'h1);
      accept(vecs[v].tgt);
      chk($sformatf("v%0d_j", v), 8'(sig_j), 8'(vecs[v].exp_j));
      chk($sformatf("v%0d_k", v), 8'(sig_k), 8'(vecs[v].exp_k));
      chk($sformatf("v%0d_busy", v), 8'(ready), 8'h0);
      step();
      chk($sformatf("v%0d_j_off", v), 8'(sig_j | sig_k), 8'h0);
      step();
      chk($sformatf("v%0d_done_early", v), 8'(done), 8'h0);
      step();
      chk($sformatf("v%0d_done", v), 8'(done), 8'h1);
      chk($sformatf("v%0d_error", v), 8'(error), 8'h0);
      chk($sformatf("v%0d_q", v), 8'(bank_q), 8'(vecs[v].tgt));
      chk($sformatf("v%0d_retry", v), 8'(retry), 8'h0);
    end
    // back-to-back accept in the done cycle
    accept(4'b0001);
    chk("b2b_j", 8'(sig_j), 8'h0);
    chk("b2b_k", 8'(sig_k), 8'h2);
    repeat (3) step();
    chk("b2b_done", 8'(done), 8'h1);
    chk("b2b_q", 8'(bank_q), 8'h1);
    // stuck bit0: three drives then error
    load(4'b0000);
    stuck0 = 1'b1;
    accept(4'b0001);
    for (int c = 0; c <= 10; c++) begin
      chk($sformatf("stuck_j_c%0d", c), 8'(sig_j), ((c % 3 == 0) && c < 9) ? 8'h1 : 8'h0);
      chk($sformatf("stuck_done_c%0d", c), 8'(done), 8'h0);
      chk($sformatf("stuck_err_c%0d", c), 8'(error), (c == 9) ? 8'h1 : 8'h0);
      if (c == 9) chk("stuck_retry", 8'(retry), 8'h2);
      step();
    end
    stuck0 = 1'b0;
    // first capture ignored: one retry
    load(4'b0000);
    skip_req = 1'b1;
    accept(4'b1111);
    for (int c = 0; c <= 7; c++) begin
      chk($sformatf("skip_j_c%0d", c), 8'(sig_j), (c == 0 || c == 3) ? 8'hf : 8'h0);
      chk($sformatf("skip_done_c%0d", c), 8'(done), (c == 6) ? 8'h1 : 8'h0);
      chk($sformatf("skip_err_c%0d", c), 8'(error), 8'h0);
      if (c == 6) chk("skip_retry", 8'(retry), 8'h1);
      step();
    end
    skip_req = 1'b0;
    // asynchronous reset during SETTLE
    load(4'b0000);
    accept(4'b1010);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_j", 8'(sig_j), 8'h0);
    chk("arst_k", 8'(sig_k), 8'h0);
    chk("arst_ready", 8'(ready), 8'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("arst_done_c%0d", c), 8'(done), 8'h0);
      chk($sformatf("arst_err_c%0d", c), 8'(error), 8'h0);
      step();
    end
    // valid while busy is ignored
    load(4'b0000);
    accept(4'b0011);
    target = 4'b1100;
    valid  = 1'b1;
    repeat (2) step();
    valid = 1'b0;
    step();
    chk("busy_done", 8'(done), 8'h1);
    chk("busy_q", 8'(bank_q), 8'h3);
    step();
    chk("busy_nodrive", 8'(sig_j | sig_k), 8'h0);
    chk("busy_ready", 8'(ready), 8'h1);
    chk("busy_q_hold", 8'(bank_q), 8'h3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
